// File: rtl/inductivo_emu_if.sv
// Control/status bundle for the inductive-sensor emulator.
// Widths must match the CNT_W/PULSE_W of the attached inductivo_emu.
interface inductivo_emu_if #(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 8
);
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   on_time;
  logic [CNT_W-1:0]   off_time;
  logic [PULSE_W-1:0] pulses;
  logic               ind;
  logic               busy;
  logic               done;
  logic [PULSE_W-1:0] pulse_cnt;

  modport master (
    output start, abort, on_time, off_time, pulses,
    input  ind, busy, done, pulse_cnt
  );

  modport slave (
    input  start, abort, on_time, off_time, pulses,
    output ind, busy, done, pulse_cnt
  );
endinterface

// File: rtl/inductivo_emu.sv
// Inductive proximity sensor emulator: generates a train of detect/clear phases on ind.
// Optional macro INDUCTIVO_EMU_LOOP_EN: pulses = 0 repeats ON/OFF until abort or rst.
module inductivo_emu #(
  parameter int CNT_W       = 16,
  parameter int PULSE_W     = 8,
  parameter int ACTIVE_HIGH = 1
) (
  input logic           clk,
  input logic           rst,
  inductivo_emu_if.slave bus
);
  localparam logic               DET_LVL   = (ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
  localparam logic               CLR_LVL   = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PULSE_W-1:0] PULSE_ONE = {{(PULSE_W-1){1'b0}}, 1'b1};
  localparam logic [PULSE_W-1:0] PULSE_MAX = {PULSE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   on_m1_r, on_m1_nxt_s;
  logic [CNT_W-1:0]   off_m1_r, off_m1_nxt_s;
  logic [CNT_W-1:0]   phase_r, phase_nxt_s;
  logic [PULSE_W-1:0] rem_r, rem_nxt_s;
  logic [PULSE_W-1:0] pulse_cnt_r, pulse_cnt_nxt_s;
  logic               done_r, done_nxt_s;
  logic               ind_r, busy_r, more_s;
`ifdef INDUCTIVO_EMU_LOOP_EN
  logic               loop_r, loop_nxt_s;
`endif

  // Phase counters hold length-1; a zero length still yields one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    len_m1 = (len == '0) ? '0 : (len - CNT_ONE);
  endfunction

  // Next-state and datapath decode for the IDLE/ON/OFF sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    on_m1_nxt_s     = on_m1_r;
    off_m1_nxt_s    = off_m1_r;
    phase_nxt_s     = phase_r;
    rem_nxt_s       = rem_r;
    pulse_cnt_nxt_s = pulse_cnt_r;
    done_nxt_s      = 1'b0;
`ifdef INDUCTIVO_EMU_LOOP_EN
    loop_nxt_s      = loop_r;
    more_s          = (rem_r != '0) || loop_r;
`else
    more_s          = (rem_r != '0);
`endif
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          on_m1_nxt_s     = len_m1(bus.on_time);
          off_m1_nxt_s    = len_m1(bus.off_time);
          phase_nxt_s     = len_m1(bus.on_time);
          rem_nxt_s       = bus.pulses;
          pulse_cnt_nxt_s = '0;
          if (bus.pulses != '0) begin
            state_nxt_s = ON;
`ifdef INDUCTIVO_EMU_LOOP_EN
            loop_nxt_s  = 1'b0;
`endif
          end else begin
`ifdef INDUCTIVO_EMU_LOOP_EN
            loop_nxt_s  = 1'b1;
            state_nxt_s = ON;
`else
            done_nxt_s  = 1'b1;
`endif
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ON: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else if (phase_r == '0) begin
          state_nxt_s     = OFF;
          phase_nxt_s     = off_m1_r;
          pulse_cnt_nxt_s = (pulse_cnt_r == PULSE_MAX) ? pulse_cnt_r : (pulse_cnt_r + PULSE_ONE);
          if (rem_r != '0) begin
            rem_nxt_s = rem_r - PULSE_ONE;
          end else begin
            rem_nxt_s = rem_r;
          end
        end else begin
          phase_nxt_s = phase_r - CNT_ONE;
        end
      end
      OFF: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else if (phase_r == '0) begin
          if (more_s) begin
            state_nxt_s = ON;
            phase_nxt_s = on_m1_r;
          end else begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end
        end else begin
          phase_nxt_s = phase_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers; ind/busy follow the next state so they change with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      on_m1_r     <= '0;
      off_m1_r    <= '0;
      phase_r     <= '0;
      rem_r       <= '0;
      pulse_cnt_r <= '0;
      done_r      <= 1'b0;
      ind_r       <= CLR_LVL;
      busy_r      <= 1'b0;
`ifdef INDUCTIVO_EMU_LOOP_EN
      loop_r      <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      on_m1_r     <= on_m1_nxt_s;
      off_m1_r    <= off_m1_nxt_s;
      phase_r     <= phase_nxt_s;
      rem_r       <= rem_nxt_s;
      pulse_cnt_r <= pulse_cnt_nxt_s;
      done_r      <= done_nxt_s;
      ind_r       <= (state_nxt_s == ON) ? DET_LVL : CLR_LVL;
      busy_r      <= (state_nxt_s != IDLE);
`ifdef INDUCTIVO_EMU_LOOP_EN
      loop_r      <= loop_nxt_s;
`endif
    end
  end

  assign bus.ind       = ind_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pulse_cnt = pulse_cnt_r;
endmodule
